// File: rtl/fifo_pkg.sv
// Shared types for the FIFO family: slice emission order for width converters.
package fifo_pkg;

  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } order_e;

endpackage

// File: rtl/width_conv_fifo.sv
// Wide-to-narrow converting FIFO: each accepted IN_W word is split into R = IN_W/OUT_W
// slices stored in a circular buffer and popped one OUT_W slice at a time.
module width_conv_fifo
  import fifo_pkg::*;
#(
  parameter int     IN_W  = 32,
  parameter int     OUT_W = 16,
  parameter int     DEPTH = 8,
  parameter order_e ORDER = MSB_FIRST
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [IN_W-1:0]            data_in,
  input  logic                       data_in_vld,
  output logic                       data_in_rdy,
  output logic [OUT_W-1:0]           data_out,
  output logic                       data_out_vld,
  input  logic                       data_out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int R  = IN_W / OUT_W;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  if ((IN_W % OUT_W) != 0 || R < 1 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 * R) begin : g_bad_params
    $error("width_conv_fifo: illegal IN_W/OUT_W/DEPTH combination");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // ready never depends on valid, and flush cancels any transfer in the same cycle.
  logic [OUT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [OUT_W-1:0] slices [R];
  logic             push;
  logic             pop;
  logic [LW-1:0]    level_nxt;

  assign data_in_rdy  = (level <= LW'(DEPTH - R));
  assign data_out_vld = (level != '0);
  assign data_out     = data_out_vld ? mem[rd_ptr] : '0;

  assign push = data_in_vld && data_in_rdy && !flush;
  assign pop  = data_out_vld && data_out_rdy && !flush;

  // Slice k is the k-th slice to leave the queue.
  always_comb begin
    for (int k = 0; k < R; k++) begin
      slices[k] = '0;
      if (ORDER == MSB_FIRST) slices[k] = data_in[IN_W-1-k*OUT_W -: OUT_W];
      else                    slices[k] = data_in[k*OUT_W +: OUT_W];
    end
  end

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(R);
      2'b01:   level_nxt = level - LW'(1);
      2'b11:   level_nxt = level + LW'(R) - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(R);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level_nxt;
    end
  end

  // Storage needs no reset; the pointers and level decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < R; k++) begin
        mem[PW'(wr_ptr + PW'(k))] <= slices[k];
      end
    end
  end

endmodule

// File: tb/tb_width_conv_fifo.sv
// Bench for width_conv_fifo: MSB_FIRST and LSB_FIRST instances share stimulus and are
// compared every cycle against queue-based reference models.
module tb_width_conv_fifo;
  import fifo_pkg::*;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int DEPTH = 8;
  localparam int R     = IN_W / OUT_W;
  localparam int LW    = $clog2(DEPTH+1);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              flush;
  logic [IN_W-1:0]   data_in;
  logic              data_in_vld;
  logic              data_out_rdy;
  logic              rdy_m, vld_m, rdy_l, vld_l;
  logic [OUT_W-1:0]  dout_m, dout_l;
  logic [LW-1:0]     lvl_m, lvl_l;

  width_conv_fifo #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ORDER(MSB_FIRST)) dut_m (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .data_in(data_in), .data_in_vld(data_in_vld), .data_in_rdy(rdy_m),
    .data_out(dout_m), .data_out_vld(vld_m), .data_out_rdy(data_out_rdy),
    .level(lvl_m)
  );

  width_conv_fifo #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ORDER(LSB_FIRST)) dut_l (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .data_in(data_in), .data_in_vld(data_in_vld), .data_in_rdy(rdy_l),
    .data_out(dout_l), .data_out_vld(vld_l), .data_out_rdy(data_out_rdy),
    .level(lvl_l)
  );

  // scoreboard
  logic [OUT_W-1:0] exp_q_m[$];
  logic [OUT_W-1:0] exp_q_l[$];
  int errors = 0;
  int checks = 0;
  int max_lvl = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [OUT_W-1:0] em, el;
    em = (exp_q_m.size() > 0) ? exp_q_m[0] : '0;
    el = (exp_q_l.size() > 0) ? exp_q_l[0] : '0;
    check("m_dout",  32'(dout_m), 32'(em));
    check("m_vld",   32'(vld_m),  32'(exp_q_m.size() > 0));
    check("m_rdy",   32'(rdy_m),  32'(exp_q_m.size() <= DEPTH - R));
    check("m_level", 32'(lvl_m),  32'(exp_q_m.size()));
    check("l_dout",  32'(dout_l), 32'(el));
    check("l_vld",   32'(vld_l),  32'(exp_q_l.size() > 0));
    check("l_rdy",   32'(rdy_l),  32'(exp_q_l.size() <= DEPTH - R));
    check("l_level", 32'(lvl_l),  32'(exp_q_l.size()));
  endtask

  // driver: applies one cycle of inputs, checks, advances the model past the edge
  task automatic cycle(input logic vld, input logic [IN_W-1:0] din, input logic ordy,
                       input logic fl, output bit acc, output bit popped,
                       output logic [OUT_W-1:0] obs);
    data_in      = din;
    data_in_vld  = vld;
    data_out_rdy = ordy;
    flush        = fl;
    #1;
    compare_outputs();
    acc    = !fl && vld && (exp_q_m.size() <= DEPTH - R);
    popped = !fl && ordy && (exp_q_m.size() > 0);
    obs    = dout_m;
    @(posedge clk);
    if (fl) begin
      exp_q_m.delete();
      exp_q_l.delete();
    end else begin
      if (popped) begin
        void'(exp_q_m.pop_front());
        void'(exp_q_l.pop_front());
      end
      if (acc) begin
        for (int k = 0; k < R; k++) begin
          exp_q_m.push_back(OUT_W'(din >> (IN_W - OUT_W * (k + 1))));
          exp_q_l.push_back(OUT_W'(din >> (OUT_W * k)));
        end
      end
    end
    if (exp_q_m.size() > max_lvl) max_lvl = exp_q_m.size();
    @(negedge clk);
  endtask

  task automatic step(input logic vld, input logic [IN_W-1:0] din, input logic ordy,
                      input logic fl);
    bit a, p;
    logic [OUT_W-1:0] o;
    cycle(vld, din, ordy, fl, a, p, o);
  endtask

  initial begin
    bit a, p;
    logic [OUT_W-1:0] o;
    logic [OUT_W-1:0] exp_next;
    int exp_lvls[5] = '{2, 4, 6, 8, 8};
    int idx, pop_cnt, budget;

    rst_n = 1'b0; flush = 1'b0; data_in = '0; data_in_vld = 1'b0; data_out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_vld",   32'(vld_m),  32'd0);
    check("rst_level", 32'(lvl_m),  32'd0);
    check("rst_dout",  32'(dout_m), 32'd0);
    check("rst_rdy",   32'(rdy_m),  32'd1);
    rst_n = 1'b1;

    // ordering
    step(1'b1, 32'hAAAA5555, 1'b1, 1'b0);
    check("ord_m_first", 32'(dout_m), 32'h0000AAAA);
    check("ord_l_first", 32'(dout_l), 32'h00005555);
    step(1'b0, '0, 1'b1, 1'b0);
    check("ord_m_second", 32'(dout_m), 32'h00005555);
    check("ord_l_second", 32'(dout_l), 32'h0000AAAA);
    step(1'b0, '0, 1'b1, 1'b0);
    check("ord_empty", 32'(vld_m), 32'd0);

    // full
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
      check("full_level", 32'(lvl_m), 32'(exp_lvls[i]));
      if (i == 3) check("full_rdy", 32'(rdy_m), 32'd0);
    end
    repeat (8) step(1'b0, '0, 1'b1, 1'b0);

    // simultaneous push and pop at level 6
    for (int i = 0; i < 3; i++) step(1'b1, 32'h2000_0000 + 32'(i), 1'b0, 1'b0);
    check("sim_pre_level", 32'(lvl_m), 32'd6);
    exp_next = exp_q_m[1];
    step(1'b1, 32'h2222_3333, 1'b1, 1'b0);
    check("sim_level", 32'(lvl_m), 32'd7);
    check("sim_head",  32'(dout_m), 32'(exp_next));

    // asynchronous reset mid-stream at level 6
    step(1'b0, '0, 1'b1, 1'b0);
    check("mrst_pre_level", 32'(lvl_m), 32'd6);
    data_out_rdy = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_vld",   32'(vld_m),  32'd0);
    check("mrst_level", 32'(lvl_m),  32'd0);
    check("mrst_dout",  32'(dout_m), 32'd0);
    check("mrst_rdy",   32'(rdy_m),  32'd1);
    exp_q_m.delete();
    exp_q_l.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h3333_4444, 1'b0, 1'b0);
    check("mrst_resume", 32'(lvl_m), 32'd2);

    // flush at level 4 with a push and pop offered
    step(1'b1, 32'h4444_5555, 1'b0, 1'b0);
    check("fl_pre_level", 32'(lvl_m), 32'd4);
    step(1'b1, 32'h5555_6666, 1'b1, 1'b1);
    check("fl_level", 32'(lvl_m), 32'd0);
    check("fl_vld",   32'(vld_m), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);

    // wrap-around stream of 20 words, slices 1..40 in order
    idx = 0; pop_cnt = 0; budget = 0; max_lvl = 0;
    while ((idx < 20 || exp_q_m.size() > 0) && budget < 300) begin
      cycle(idx < 20, 32'h0001_0002 + 32'(idx) * 32'h0002_0002, 1'b1, 1'b0, a, p, o);
      if (a) idx++;
      if (p) begin
        check("wrap_order", 32'(o), 32'(pop_cnt + 1));
        pop_cnt++;
      end
      budget++;
    end
    check("wrap_timeout", 32'(budget < 300), 32'd1);
    check("wrap_count",   32'(pop_cnt), 32'd40);
    check("wrap_max_lvl", 32'(max_lvl <= DEPTH), 32'd1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 24) == 0));
    end
    repeat (10) step(1'b0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/width_conv_fifo.md
WIDTH_CONV_FIFO -- requirements
Module: width_conv_fifo

Interface
REQ-001 SHALL have parameter IN_W, default 32, input word width in bits.
REQ-002 SHALL have parameter OUT_W, default 16, output word width in bits; R = IN_W/OUT_W.
REQ-003 SHALL have parameter DEPTH, default 8, storage capacity in OUT_W words.
REQ-004 SHALL have parameter ORDER (fifo_pkg::order_e), default MSB_FIRST, slice emission order.
REQ-005 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-006 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port flush  input  1  synchronous clear of contents.
REQ-008 SHALL have port data_in  input  IN_W  input word.
REQ-009 SHALL have port data_in_vld  input  1  input word valid.
REQ-010 SHALL have port data_in_rdy  output  1  room for one full input word.
REQ-011 SHALL have port data_out  output  OUT_W  head-of-queue slice.
REQ-012 SHALL have port data_out_vld  output  1  queue non-empty.
REQ-013 SHALL have port data_out_rdy  input  1  consumer accepts slice.
REQ-014 SHALL have port level  output  $clog2(DEPTH+1)  stored OUT_W word count.

Function
REQ-015 SHALL fail elaboration unless IN_W % OUT_W == 0, R >= 1, DEPTH is a power of two, and DEPTH >= 2*R.
REQ-016 SHALL store slices in a circular buffer of DEPTH entries, with read/write pointers of $clog2(DEPTH) bits wrapping modulo DEPTH.
REQ-017 SHALL drive data_in_rdy = (level <= DEPTH - R), combinationally from registered state only.
REQ-018 SHALL drive data_out_vld = (level > 0).
REQ-019 SHALL drive data_out = entry at read pointer when level > 0, else all zeros (never X).
REQ-020 SHALL accept an input word on a rising edge with data_in_vld && data_in_rdy, writing R slices at consecutive write-pointer positions.
REQ-021 SHALL, for ORDER=MSB_FIRST, emit slice data_in[IN_W-1 -: OUT_W] first; for LSB_FIRST, data_in[OUT_W-1:0] first.
REQ-022 SHALL pop one slice on a rising edge with data_out_vld && data_out_rdy.
REQ-023 SHALL present the first slice of an accepted word on data_out in the cycle after acceptance (1-cycle latency when empty).
REQ-024 SHALL update level on a simultaneous push and pop as level + R - 1 in one cycle.
REQ-025 SHALL hold data_out stable while data_out_vld && !data_out_rdy.
REQ-026 SHALL, on flush=1, set both pointers and level to 0 next edge; flush overrides any same-cycle push and pop, which are discarded.
REQ-027 SHALL never overflow or underflow; pushes with data_in_rdy=0 and pops with data_out_vld=0 have no effect.

Reset
REQ-028 SHALL, while rst_n=0, immediately force pointers=0, level=0, data_out_vld=0, data_out=0, data_in_rdy=1.
REQ-029 SHALL discard all stored data on reset, including reset asserted mid-transfer; storage array contents need no reset.
REQ-030 SHALL resume accepting input on the first rising edge after rst_n deasserts.

Structure
REQ-031 SHALL import typedef enum order_e {MSB_FIRST, LSB_FIRST} from shared package fifo_pkg.
REQ-032 SHALL be a single module with no sub-modules; R-slice write demux and pointer arithmetic are inline.

Verification
REQ-033 SHALL verify reset: rst_n=0 mid-stream at level=6 -> data_out_vld=0, level=0, data_out=16'h0, data_in_rdy=1 without a clock edge.
REQ-034 SHALL verify ordering: defaults, write 32'hAAAA5555, data_out_rdy=1 -> 16'hAAAA next cycle, then 16'h5555, then data_out_vld=0; with ORDER=LSB_FIRST -> 16'h5555 then 16'hAAAA.
REQ-035 SHALL verify full: data_out_rdy=0, offer 5 words -> levels 2,4,6,8; data_in_rdy=0 at level 8; 5th word not accepted.
REQ-036 SHALL verify simultaneous events: at level=6, push and pop in one cycle -> level=7, head advances by one slice.
REQ-037 SHALL verify wrap-around: stream 20 words 32'h0001_0002 .. incrementing with data_out_rdy=1 -> 40 slices in exact order, no loss, level never exceeds 8.
REQ-038 SHALL verify flush: at level=4, flush=1 with data_in_vld=1 and data_out_rdy=1 -> level=0 next cycle, data_out_vld=0, the offered word is dropped.
